// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - queues ALU requests, holds operands stable for SETTLE edges, captures the result
module alu_issue_stage #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [2:0]  in_cmd,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_cmd,
  input  logic [31:0] alu_result,
  input  logic        alu_carryout,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_carryout,
  output logic        out_zero,
  output logic        out_overflow,
  output logic [2:0]  out_cmd,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [66:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            push;
  logic            pop;
  logic [66:0]     head;

  assign in_ready = (count < (AW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  // Pop uses the registered count, so a same-edge push can never be bypassed.
  assign pop      = (state == S_IDLE) && (count != '0);
  assign head     = mem[rd_ptr];
  assign busy     = (state != S_IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b, in_cmd};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_cmd      <= '0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_carryout <= 1'b0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
      out_cmd      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            {alu_a, alu_b, alu_cmd} <= head;
            cnt   <= CW'(SETTLE);
            state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          cnt <= cnt - CW'(1);
          // Capture on the last settling edge; operands stay put until the next pop.
          if (cnt == CW'(1)) begin
            out_result   <= alu_result;
            out_carryout <= alu_carryout;
            out_zero     <= alu_zero;
            out_overflow <= alu_overflow;
            out_cmd      <= alu_cmd;
            out_valid    <= 1'b1;
            state        <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - randomized and directed checks of alu_issue_stage against a queue-based model
module tb_alu_issue_stage;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 4;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        z;
    logic        v;
    logic [2:0]  cmd;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_cmd;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_cmd;
  logic [31:0] alu_result;
  logic        alu_carryout, alu_zero, alu_overflow;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_carryout, out_zero, out_overflow;
  logic [2:0]  out_cmd;
  logic        busy;

  int   passed = 0;
  int   total  = 0;
  res_t got_q[$];
  res_t exp_q[$];
  res_t alu_o;

  always #5 clk = ~clk;

  function automatic res_t ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    res_t        o;
    logic [32:0] s;
    o     = '0;
    o.cmd = c;
    case (c)
      3'd0: begin
        s   = {1'b0, a} + {1'b0, b};
        o.r = s[31:0];
        o.c = s[32];
        o.v = (a[31] == b[31]) && (o.r[31] != a[31]);
      end
      3'd1: begin
        s   = {1'b0, a} + {1'b0, ~b} + 33'd1;
        o.r = s[31:0];
        o.c = s[32];
        o.v = (a[31] != b[31]) && (o.r[31] != a[31]);
      end
      3'd2: o.r = a ^ b;
      3'd3: o.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: o.r = a & b;
      3'd5: o.r = ~(a & b);
      3'd6: o.r = ~(a | b);
      default: o.r = a | b;
    endcase
    o.z = (o.r == 32'd0);
    return o;
  endfunction

  // Stand-in for the team ALU on the alu_* ports.
  always_comb alu_o = ref_alu(alu_a, alu_b, alu_cmd);
  assign alu_result   = alu_o.r;
  assign alu_carryout = alu_o.c;
  assign alu_zero     = alu_o.z;
  assign alu_overflow = alu_o.v;

  alu_issue_stage #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_cmd(in_cmd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
    .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carryout(out_carryout), .out_zero(out_zero), .out_overflow(out_overflow),
    .out_cmd(out_cmd), .busy(busy)
  );

  // A result is consumed at the edge following a negedge that sees valid && ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready)
      got_q.push_back({out_result, out_carryout, out_zero, out_overflow, out_cmd});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d results", got_q.size());
    $fatal(1);
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    int t = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_cmd = c;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL push_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_for(input int n);
    int t = 0;
    while (got_q.size() < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cmd = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL reset_ctrl: ready/valid/busy=%b required 100", {in_ready, out_valid, busy});
    else passed++;
    total++;
    if ({alu_a, alu_b, alu_cmd} !== 67'd0) $display("FAIL reset_alu: alu_a=%h alu_b=%h alu_cmd=%0d required 0", alu_a, alu_b, alu_cmd);
    else passed++;
    total++;
    if ({out_result, out_carryout, out_zero, out_overflow, out_cmd} !== 38'd0) $display("FAIL reset_out: out_result=%h out_cmd=%0d required 0", out_result, out_cmd);
    else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    int   lat = -1;
    res_t r;
    got_q.delete();
    out_ready = 1'b1;
    push(32'd2, 32'd1, 3'd0);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        total++;
        if (busy !== 1'b1) $display("FAIL busy_queued: busy=%b required 1", busy);
        else passed++;
      end
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    total++;
    if (lat != SETTLE + 1) $display("FAIL latency: out_valid after %0d edges required %0d", lat, SETTLE + 1);
    else passed++;
    wait_for(1);
    r = (got_q.size() > 0) ? got_q.pop_front() : '0;
    total++;
    if (r !== {32'd3, 1'b0, 1'b0, 1'b0, 3'd0}) $display("FAIL add_2_1: got %h required %h", r, {32'd3, 1'b0, 1'b0, 1'b0, 3'd0});
    else passed++;
    @(negedge clk);
    total++;
    if ({busy, out_valid, out_result} !== {1'b0, 1'b0, 32'd3}) $display("FAIL after_handshake: busy=%b valid=%b result=%h required 0 0 3", busy, out_valid, out_result);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_flags();
    res_t exp [5];
    res_t r;
    got_q.delete();
    out_ready = 1'b1;
    exp[0] = {32'd0,          1'b1, 1'b1, 1'b0, 3'd1};
    exp[1] = {32'd1,          1'b0, 1'b0, 1'b0, 3'd3};
    exp[2] = {32'd0,          1'b0, 1'b1, 1'b0, 3'd3};
    exp[3] = {32'h8000_0000,  1'b0, 1'b0, 1'b1, 3'd0};
    exp[4] = {32'hFFFF_FFF4,  1'b1, 1'b0, 1'b0, 3'd0};
    push(32'd100, 32'd100, 3'd1);
    push(32'd2, 32'd4, 3'd3);
    push(32'd4, 32'd2, 3'd3);
    push(32'h7FFF_FFFF, 32'd1, 3'd0);
    push(32'hFFFF_FFFB, 32'hFFFF_FFF9, 3'd0);
    wait_for(5);
    for (int i = 0; i < 5; i++) begin
      r = (got_q.size() > 0) ? got_q.pop_front() : '0;
      total++;
      if (r !== exp[i]) $display("FAIL flags_%0d: got %h required %h", i, r, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int   acc = 0;
    logic full_seen = 1'b0;
    res_t r;
    got_q.delete();
    exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_cmd = 3'($urandom_range(0, 7));
      @(negedge clk);
      if (in_ready) begin
        acc++;
        exp_q.push_back(ref_alu(in_a, in_b, in_cmd));
      end else if (i == 5) begin
        full_seen = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++;
    if (acc != 5 || !full_seen) $display("FAIL backpressure_accept: accepted=%0d full_seen=%b required 5 1", acc, full_seen);
    else passed++;
    out_ready = 1'b1;
    wait_for(5);
    total++;
    if (got_q.size() != 5) $display("FAIL backpressure_count: got %0d results required 5", got_q.size());
    else passed++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      r = got_q.pop_front();
      total++;
      if (r !== exp_q[0]) $display("FAIL backpressure_order: got %h required %h", r, exp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, in_ready} !== 2'b01) $display("FAIL backpressure_drain: busy=%b in_ready=%b required 0 1", busy, in_ready);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_logic();
    res_t exp [4];
    res_t r;
    logic [31:0] a = 32'b1101111;
    logic [31:0] b = 32'b1111100;
    got_q.delete();
    out_ready = 1'b1;
    exp[0] = {32'b1101100,  3'b000, 3'd4};
    exp[1] = {~32'b1101100, 3'b000, 3'd5};
    exp[2] = {~32'b1111111, 3'b000, 3'd6};
    exp[3] = {32'b1111111,  3'b000, 3'd7};
    for (int i = 0; i < 4; i++) push(a, b, 3'(4 + i));
    wait_for(4);
    for (int i = 0; i < 4; i++) begin
      r = (got_q.size() > 0) ? got_q.pop_front() : '0;
      total++;
      if (r !== exp[i]) $display("FAIL logic_%0d: got %h required %h", i, r, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_midflight();
    logic any_valid = 1'b0;
    got_q.delete();
    out_ready = 1'b1;
    push(32'd1, 32'd2, 3'd7);
    push(32'd3, 32'd4, 3'd2);
    push(32'd5, 32'd6, 3'd1);
    push(32'd7, 32'd8, 3'd0);
    total++;
    if ({alu_cmd, busy, in_ready} !== {3'd7, 1'b1, 1'b1}) $display("FAIL pre_reset: alu_cmd=%0d busy=%b in_ready=%b required 7 1 1", alu_cmd, busy, in_ready);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, in_ready, busy, alu_cmd} !== {1'b0, 1'b1, 1'b0, 3'd0}) $display("FAIL async_reset: valid=%b ready=%b busy=%b alu_cmd=%0d required 0 1 0 0", out_valid, in_ready, busy, alu_cmd);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid || busy) any_valid = 1'b1;
    end
    total++;
    if (any_valid || got_q.size() != 0) $display("FAIL stale_after_reset: activity=%b results=%0d required 0 0", any_valid, got_q.size());
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic prev_hold = 1'b0;
    res_t prev_res  = '0;
    res_t cur;
    res_t r;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = $urandom;
      in_b      = ($urandom_range(0, 7) == 0) ? in_a : $urandom;
      in_cmd    = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) exp_q.push_back(ref_alu(in_a, in_b, in_cmd));
      cur = {out_result, out_carryout, out_zero, out_overflow, out_cmd};
      if (prev_hold) begin
        total++;
        if (!out_valid || cur !== prev_res) $display("FAIL hold_stable: valid=%b out=%h required 1 %h", out_valid, cur, prev_res);
        else passed++;
      end
      prev_hold = out_valid && !out_ready;
      prev_res  = cur;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_for(exp_q.size());
    total++;
    if (got_q.size() != exp_q.size()) $display("FAIL random_count: got %0d results required %0d", got_q.size(), exp_q.size());
    else passed++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      r = got_q.pop_front();
      total++;
      if (r !== exp_q[0]) $display("FAIL random_result: got %h required %h", r, exp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_flags();
    test_backpressure();
    test_logic();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter: DEPTH, 4, request FIFO entries (power of two, >=2).
REQ-002 Parameter: SETTLE, 4, clock edges the ALU inputs are held stable before capture (>=1).
REQ-003 Port: clk  input  1  rising-edge clock; sole clock.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  request present.
REQ-006 Port: in_ready  output  1  request FIFO can accept.
REQ-007 Port: in_a, in_b  input  32 each  operands.
REQ-008 Port: in_cmd  input  3  ALU opcode (0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR).
REQ-009 Port: alu_a, alu_b  output  32 each  registered operands to ALU operandA/operandB.
REQ-010 Port: alu_cmd  output  3  registered opcode to ALU command.
REQ-011 Port: alu_result  input  32, alu_carryout, alu_zero, alu_overflow  input  1 each  ALU outputs.
REQ-012 Port: out_valid  output  1  captured result available.
REQ-013 Port: out_ready  input  1  consumer accepts result.
REQ-014 Port: out_result  output  32, out_carryout, out_zero, out_overflow  output  1 each, out_cmd  output  3  captured result, flags and opcode.
REQ-015 Port: busy  output  1  high whenever state != IDLE or the FIFO is non-empty.

Function
REQ-016 The request FIFO SHALL store {in_a, in_b, in_cmd} on every edge where in_valid && in_ready.
REQ-017 in_ready SHALL equal (count < DEPTH), independent of any same-cycle pop; no push occurs when full.
REQ-018 Simultaneous push and pop with FIFO non-full SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-019 No bypass: an entry pushed at edge N SHALL be poppable no earlier than edge N+1.
REQ-020 FSM states: IDLE, SETTLE, HOLD.
REQ-021 IDLE: if FIFO non-empty, at the edge pop the head, load alu_a/alu_b/alu_cmd, load settle counter with SETTLE, go SETTLE; otherwise stay.
REQ-022 SETTLE: counter decrements each edge; at the edge where counter == 1, latch alu_result/flags into out_* plus out_cmd = alu_cmd, set out_valid, go HOLD.
REQ-023 alu_a/alu_b/alu_cmd SHALL remain constant from pop until the next pop.
REQ-024 Latency: request accepted at edge N (FIFO empty, IDLE) -> popped at edge N+1 -> out_valid high after edge N+1+SETTLE.
REQ-025 HOLD: out_* stable while out_valid && !out_ready; on out_valid && out_ready clear out_valid, go IDLE.
REQ-026 out_* SHALL keep last captured values after handshake until the next capture.
REQ-027 Results SHALL emerge in request order; no request dropped or duplicated.
REQ-028 Flags are passed through unmodified; the block performs no arithmetic on data.

Reset
REQ-029 rst_n low SHALL immediately clear: FIFO (count 0, pointers 0), state IDLE, counter 0, alu_a/alu_b 0, alu_cmd 0 (ADD), out_valid 0, out_* 0, busy 0.
REQ-030 Reset asserted mid-SETTLE or mid-HOLD SHALL discard all in-flight and queued requests; in_ready is 1 after reset release (DEPTH>0).

Verification (bench instantiates the team ALU on the alu_* ports, SETTLE=4, DEPTH=4)
REQ-031 Push ADD a=2 b=1 at edge 0, out_ready=1 -> out_valid after edge 5, out_result=3, out_zero=0, out_cmd=0.
REQ-032 Push SUB a=100 b=100 -> out_result=0, out_zero=1; then SLT a=2 b=4 -> out_result=1; SLT a=4 b=2 -> out_result=0.
REQ-033 Push ADD a=32'h7FFFFFFF b=1 -> out_result=32'h80000000, out_overflow=1; ADD a=-5 b=-7 -> out_result=-12, out_carryout=1, out_overflow=0.
REQ-034 out_ready=0, push every cycle -> 5 requests accepted (1 in ALU, 4 queued), 6th sees in_ready=0; release out_ready -> 5 results in push order, FIFO empty, busy=0.
REQ-035 Push AND/NAND/NOR/OR with a=32'b1101111 b=32'b1111100 back-to-back -> results 32'b1101100, ~32'b1101100, ~32'b1111111, 32'b1111111 in order.
REQ-036 Assert rst_n=0 two edges into SETTLE with 3 queued -> out_valid=0, in_ready=1, busy=0, alu_cmd=0 immediately; no stale result after release.
